// File: rtl/conv_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_gen_if
// Bundles the pixel-stream, row-buffer and window handshake signals of
// conv_window_gen.
//   px_in / px_valid / px_ready : raster pixel stream into the window generator
//   taps_in                     : row-buffer outputs, slice k = delay of k+1 rows
//   rb_en                       : shift enable for every row buffer in the chain
//   win_out / win_valid / win_ready : KSIZE x KSIZE window towards the MAC array
//   frame_done                  : one-cycle pulse after the last pixel of a frame
// Modports: master = environment (pixel source, row buffers, window consumer),
//           slave  = conv_window_gen.
// -----------------------------------------------------------------------------
interface conv_window_gen_if #(
    parameter int KSIZE     = 5,
    parameter int BIT_WIDTH = 8
) ();
    logic [BIT_WIDTH-1:0]               px_in;
    logic                               px_valid;
    logic                               px_ready;
    logic [(KSIZE-1)*BIT_WIDTH-1:0]     taps_in;
    logic                               rb_en;
    logic [KSIZE*KSIZE*BIT_WIDTH-1:0]   win_out;
    logic                               win_valid;
    logic                               win_ready;
    logic                               frame_done;

    modport master (
        output px_in, px_valid, taps_in, win_ready,
        input  px_ready, rb_en, win_out, win_valid, frame_done
    );

    modport slave (
        input  px_in, px_valid, taps_in, win_ready,
        output px_ready, rb_en, win_out, win_valid, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Sliding-window generator placed after a chain of KSIZE-1 row buffers.
// Each accepted raster pixel shifts the KSIZE x KSIZE window left by one
// column; the new right-hand column is built from the row-buffer taps (older
// rows) and the incoming pixel (newest row). Windows that would straddle an
// image edge are suppressed, and a pulse marks the end of each frame.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - conv_window_gen_if.slave (px_in/px_valid/px_ready, taps_in, rb_en,
//          win_out/win_valid/win_ready, frame_done)
//
// Build option:
//   CONV_WINDOW_STRIDE2_EN - when defined, only windows whose top-left corner
//   lies on even row and even column offsets are emitted (stride 2).
//   Pixel acceptance, rb_en and frame_done are the same in both builds.
// -----------------------------------------------------------------------------
module conv_window_gen #(
    parameter int COLS      = 32,
    parameter int ROWS      = 32,
    parameter int KSIZE     = 5,
    parameter int BIT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    conv_window_gen_if.slave bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = BIT_WIDTH;
    localparam int WW = KSIZE * KSIZE * BIT_WIDTH;

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KSIZE - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FILL  = RW'(KSIZE - 2);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
`ifdef CONV_WINDOW_STRIDE2_EN
    // (cnt - (KSIZE-1)) is even exactly when cnt's LSB matches (KSIZE-1)'s LSB
    localparam logic KPAR = 1'((KSIZE - 1) % 2);
`endif

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   col_cnt_r;
    logic [RW-1:0]   row_cnt_r;
    logic [WW-1:0]   win_r;
    logic            win_valid_r;
    logic            frame_done_r;

    logic            px_ready_s;
    logic            acc_s;
    logic            emit_s;
    logic            last_px_s;
    logic            fill_done_s;

    // Handshake: a pending window blocks new pixels unless it is consumed now
    assign px_ready_s = !win_valid_r || bus.win_ready;
    assign acc_s      = bus.px_valid && px_ready_s;

    assign bus.px_ready   = px_ready_s;
    assign bus.rb_en      = acc_s;
    assign bus.win_out    = win_r;
    assign bus.win_valid  = win_valid_r;
    assign bus.frame_done = frame_done_r;

    // Position decode and window-emission decision for the pixel being accepted
    always_comb begin
        last_px_s   = (col_cnt_r == COL_LAST) && (row_cnt_r == ROW_LAST);
        fill_done_s = (col_cnt_r == COL_LAST) && (row_cnt_r == ROW_FILL);
        emit_s      = 1'b0;
        if (acc_s && (state_r == S_RUN) && (col_cnt_r >= COL_FIRST)) begin
`ifdef CONV_WINDOW_STRIDE2_EN
            emit_s = (row_cnt_r[0] == KPAR) && (col_cnt_r[0] == KPAR);
`else
            emit_s = 1'b1;
`endif
        end else begin
            emit_s = 1'b0;
        end
    end

    // Position counters, fill/run FSM, window-valid and frame-done registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_FILL;
            col_cnt_r    <= '0;
            row_cnt_r    <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (acc_s) begin
                if (col_cnt_r == COL_LAST) begin
                    col_cnt_r <= '0;
                    if (row_cnt_r == ROW_LAST) begin
                        row_cnt_r <= '0;
                    end else begin
                        row_cnt_r <= row_cnt_r + ROW_ONE;
                    end
                end else begin
                    col_cnt_r <= col_cnt_r + COL_ONE;
                end

                case (state_r)
                    S_FILL: begin
                        if (fill_done_s) begin
                            state_r <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (last_px_s) begin
                            state_r <= S_FILL;
                        end
                    end
                    default: begin
                        state_r <= S_FILL;
                    end
                endcase

                if (last_px_s) begin
                    frame_done_r <= 1'b1;
                end
            end

            // A new window wins over a simultaneous consume, so nothing is lost
            if (emit_s) begin
                win_valid_r <= 1'b1;
            end else if (bus.win_ready) begin
                win_valid_r <= 1'b0;
            end
        end
    end

    // Window shift register: shift left one column, load new right-hand column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_r <= '0;
        end else if (acc_s) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_r[(r*KSIZE + c)*PW +: PW] <= win_r[(r*KSIZE + c + 1)*PW +: PW];
                end
            end
            // Row r (oldest first) takes the tap delayed by KSIZE-1-r rows
            for (int r = 0; r < KSIZE - 1; r++) begin
                win_r[(r*KSIZE + KSIZE - 1)*PW +: PW] <= bus.taps_in[(KSIZE-2-r)*PW +: PW];
            end
            win_r[(KSIZE*KSIZE - 1)*PW +: PW] <= bus.px_in;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int K    = 5;
    localparam int B    = 8;
    localparam int N    = COLS * ROWS;
    localparam int WW   = K * K * B;
`ifdef CONV_WINDOW_STRIDE2_EN
    localparam int STEP    = 2;
    localparam int WIN_LIT = 196;
`else
    localparam int STEP    = 1;
    localparam int WIN_LIT = 784;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_gen_if #(.KSIZE(K), .BIT_WIDTH(B)) bus ();

    conv_window_gen #(.COLS(COLS), .ROWS(ROWS), .KSIZE(K), .BIT_WIDTH(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [B-1:0]  img [N];
    logic [WW-1:0] exp_q [$];
    logic [B-1:0]  rb [K-1][COLS];
    int            win_cnt = 0;
    bit            chk_en = 1'b0;
    bit            ramp_frame = 1'b0;
    int            acc_idx = 0;
    bit            fd_pend = 1'b0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Behavioural row-buffer chain: COLS-deep shift registers advanced by rb_en
    always @(posedge clk) begin
        if (bus.rb_en) begin
            for (int k = 0; k < K - 1; k++) begin
                for (int c = COLS - 1; c > 0; c--) rb[k][c] <= rb[k][c-1];
                rb[k][0] <= (k == 0) ? bus.px_in : rb[k-1][COLS-1];
            end
        end
    end

    always_comb begin
        bus.taps_in = '0;
        for (int k = 0; k < K - 1; k++) bus.taps_in[k*B +: B] = rb[k][COLS-1];
    end

    // Reference: fill the image and list every window it must produce, in order
    task automatic load_frame(input bit ramp);
        logic [WW-1:0] w;
        for (int i = 0; i < N; i++) img[i] = ramp ? B'(i) : B'($urandom);
        for (int r0 = 0; r0 <= ROWS - K; r0 += STEP) begin
            for (int c0 = 0; c0 <= COLS - K; c0 += STEP) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        w[(r*K + c)*B +: B] = img[(r0 + r)*COLS + c0 + c];
                exp_q.push_back(w);
            end
        end
    endtask

    // Per-cycle compare against the reference
    always @(negedge clk) begin
        logic [WW-1:0] w;
        logic          acc;
        if (!rst) begin
            acc_idx = 0;
            fd_pend = 1'b0;
        end else if (chk_en) begin
            acc = bus.px_valid && bus.px_ready;
            check("frame_done", WW'(bus.frame_done), WW'(fd_pend));
            check("rb_en", WW'(bus.rb_en), WW'(acc));
            if (!bus.win_valid) check("px_ready_idle", WW'(bus.px_ready), WW'(1));
            else if (!bus.win_ready) check("px_ready_bp", WW'(bus.px_ready), WW'(0));
            if (bus.win_valid && bus.win_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL win_extra: got window %0h expected none", bus.win_out);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.win_out !== w) begin
                        failures++;
                        $display("FAIL win_out: got %0h expected %0h", bus.win_out, w);
                    end
                end
`ifdef CONV_WINDOW_STRIDE2_EN
                if (ramp_frame && win_cnt == 1)
                    check("stride_second_tl", WW'(bus.win_out[B-1:0]), WW'(2));
`endif
                win_cnt++;
            end
            fd_pend = acc && (acc_idx == N - 1);
            if (acc) acc_idx = (acc_idx == N - 1) ? 0 : acc_idx + 1;
        end
    end

    // Feed one frame (or stop before pixel index stop_at)
    // wr_mode: 0 = always ready, 1 = random ready, 2 = 10-cycle stall on first window
    task automatic run_frame(input int wr_mode, input bit gaps, input bit timing, input int stop_at);
        int idx = 0;
        int cyc = 0;
        int last_acc = -1;
        int bp_cnt = 0;
        logic [WW-1:0] held = '0;
        while (idx < N && idx != stop_at && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (timing && last_acc == 131) check("pre_first_valid", WW'(bus.win_valid), WW'(0));
            if (timing && last_acc == 132) begin
                check("first_valid", WW'(bus.win_valid), WW'(1));
                check("first_el00", WW'(bus.win_out[B-1:0]), WW'(0));
                check("first_el44", WW'(bus.win_out[(K*K-1)*B +: B]), WW'(132));
            end
            last_acc = -1;
            bus.win_ready = (wr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.px_valid  = !gaps || ($urandom_range(0, 1) == 1);
            bus.px_in     = img[idx];
            if (wr_mode == 2 && bp_cnt < 10 && bus.win_valid) begin
                if (bp_cnt == 0) held = bus.win_out;
                else check("bp_win_stable", bus.win_out, held);
                bus.win_ready = 1'b0;
                bus.px_valid  = 1'b1;
                bp_cnt++;
                #1;
                check("bp_px_ready", WW'(bus.px_ready), WW'(0));
                check("bp_rb_en", WW'(bus.rb_en), WW'(0));
            end else begin
                #1;
            end
            if (bus.px_valid && bus.px_ready) begin
                last_acc = idx;
                idx++;
            end
        end
        if (idx < N && idx != stop_at) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got %0d pixels accepted expected %0d", idx, N);
        end
        if (wr_mode == 2) check("bp_cycles", WW'(bp_cnt), WW'(10));
    endtask

    task automatic drain_and_count();
        @(posedge clk); #1;
        bus.px_valid  = 1'b0;
        bus.win_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("win_remaining", WW'(exp_q.size()), WW'(0));
        check("win_count", WW'(win_cnt), WW'(WIN_LIT));
    endtask

    initial begin
        bus.px_valid  = 1'b0;
        bus.px_in     = '0;
        bus.win_ready = 1'b1;

        // Asynchronous reset asserted mid-cycle
        #3 rst = 1'b0;
        #1;
        check("rst_win_valid", WW'(bus.win_valid), WW'(0));
        check("rst_frame_done", WW'(bus.frame_done), WW'(0));
        check("rst_win_out", bus.win_out, WW'(0));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_px_ready", WW'(bus.px_ready), WW'(1));
        chk_en = 1'b1;

        // Ramp frame, no gaps, always ready: latency and first-window contents
        ramp_frame = 1'b1;
        win_cnt = 0;
        load_frame(1'b1);
        run_frame(0, 1'b0, 1'b1, -1);
        drain_and_count();

        // Ramp frame with a 10-cycle stall on the first window
        win_cnt = 0;
        load_frame(1'b1);
        run_frame(2, 1'b0, 1'b0, -1);
        drain_and_count();

        // Ramp frame with random input gaps and random consumer readiness
        win_cnt = 0;
        load_frame(1'b1);
        run_frame(1, 1'b1, 1'b0, -1);
        drain_and_count();

        // Random frame aborted by reset at pixel index 500
        ramp_frame = 1'b0;
        win_cnt = 0;
        load_frame(1'b0);
        run_frame(1, 1'b1, 1'b0, 500);
        @(posedge clk); #3;
        bus.px_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_win_valid", WW'(bus.win_valid), WW'(0));
        check("mid_rst_frame_done", WW'(bus.frame_done), WW'(0));
        check("mid_rst_win_out", bus.win_out, WW'(0));
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_px_ready", WW'(bus.px_ready), WW'(1));

        // Fresh random frame after the reset
        win_cnt = 0;
        load_frame(1'b0);
        run_frame(1, 1'b1, 1'b0, -1);
        drain_and_count();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
